// File: rtl/fp_rs_preprocess_pipe.sv
// Multi-operand FP register-source preprocessor: NaN-box check, classify, CLZ prenormalize, single->double widen.
// Optional flush-to-zero of subnormal inputs via FP_PRENORM_FTZ_EN (adds the ftz port).
package fp_rs_pkg;
  typedef struct packed {
    logic [63:0] rs;
    logic        single;
    logic        daz;
    logic [3:0]  special;
    logic        boxed;
    logic        hidden;
    logic [5:0]  clz;
  } cls_t;

  typedef struct packed {
    logic [63:0] dbl;
    logic [3:0]  special;
    logic        boxed;
    logic        hidden;
    logic [51:0] frac;
    logic [5:0]  shift;
  } res_t;
endpackage

module fp_rs_lane
  import fp_rs_pkg::*;
(
  input  logic [63:0] rs,
  input  logic        single,
  input  logic        ftz,
  output cls_t        cls,
  input  cls_t        cls_q,
  output res_t        res
);
  logic        boxed, daz, e_ones, e_zero, f_zero, qbit, hid, nan;
  logic [63:0] op;
  logic [51:0] f52a, f52b, frac;
  logic [53:0] vec;
  logic [5:0]  clz;
  logic [3:0]  sp;
  logic [10:0] ex;

  // Front half: classification and leading-zero count.
  always_comb begin
    boxed = &rs[63:32];
    if (single) daz = ftz & boxed & ~|rs[30:23] & |rs[22:0];
    else        daz = ftz & ~|rs[62:52] & |rs[51:0];
    op = rs;
    if (daz) begin
      if (single) op[22:0] = '0;
      else        op[51:0] = '0;
    end
    if (single) begin
      e_ones = &op[30:23];
      e_zero = ~|op[30:23];
      f_zero = ~|op[22:0];
      qbit   = op[22];
      f52a   = {op[22:0], 29'b0};
    end else begin
      e_ones = &op[62:52];
      e_zero = ~|op[62:52];
      f_zero = ~|op[51:0];
      qbit   = op[51];
      f52a   = op[51:0];
    end
    hid = ~e_zero;
    nan = e_ones & ~f_zero;
    sp  = {e_ones & f_zero, nan & ~qbit, nan & qbit, e_zero & f_zero};
    // An unboxed single is treated as the canonical quiet NaN.
    if (single) sp = {sp[3] & boxed, sp[2] & boxed, sp[1] | ~boxed, sp[0] & boxed};
    vec = {hid, f52a, 1'b1};
    clz = 6'd53;
    for (int i = 0; i < 54; i++)
      if (vec[i]) clz = 6'(53 - i);
    cls.rs      = op;
    cls.single  = single;
    cls.daz     = daz;
    cls.special = sp;
    cls.boxed   = boxed;
    cls.hidden  = hid;
    cls.clz     = clz;
  end

  // Back half: normalizing shift and widened exponent.
  always_comb begin
    f52b = cls_q.single ? {cls_q.rs[22:0], 29'b0} : cls_q.rs[51:0];
    frac = f52b << cls_q.clz;
    ex   = (cls_q.rs[30:23] == 8'd0) ? 11'd897 - 11'(cls_q.clz)
                                     : 11'd896 + 11'(cls_q.rs[30:23]);
    if (!cls_q.single)                          res.dbl = cls_q.rs;
    else if (cls_q.special[2] | cls_q.special[1]) res.dbl = 64'h7FF8_0000_0000_0000;
    else if (cls_q.special[3])                  res.dbl = {cls_q.rs[31], 11'h7FF, 52'b0};
    else if (cls_q.special[0])                  res.dbl = {cls_q.rs[31], 63'b0};
    else                                        res.dbl = {cls_q.rs[31], ex, frac};
    res.special = cls_q.special;
    res.boxed   = cls_q.boxed;
    res.hidden  = cls_q.hidden;
    res.frac    = frac;
    res.shift   = (cls_q.single | cls_q.daz) ? 6'd0 : cls_q.clz;
  end
endmodule

module fp_rs_preprocess_pipe
  import fp_rs_pkg::*;
#(
  parameter int NUM_OPERANDS = 3,
  parameter int LATENCY      = 2,
  parameter int ID_W         = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
`ifdef FP_PRENORM_FTZ_EN
  input  logic                              ftz,
`endif
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ID_W-1:0]                   in_id,
  input  logic [NUM_OPERANDS-1:0][63:0]     in_rs,
  input  logic [NUM_OPERANDS-1:0]           in_single,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ID_W-1:0]                   out_id,
  output logic [NUM_OPERANDS-1:0][63:0]     out_double,
  output logic [NUM_OPERANDS-1:0][3:0]      out_special,
  output logic [NUM_OPERANDS-1:0]           out_is_boxed,
  output logic [NUM_OPERANDS-1:0]           out_hidden,
  output logic [NUM_OPERANDS-1:0][51:0]     out_prenorm_frac,
  output logic [NUM_OPERANDS-1:0][5:0]      out_prenorm_shift
);
`ifndef FP_PRENORM_FTZ_EN
  logic ftz;
  assign ftz = 1'b0;
`endif

  logic [LATENCY:1]              vld_pipe;
  logic [LATENCY:0]              vld_src;
  logic [LATENCY+1:1]            en;
  cls_t [NUM_OPERANDS-1:0]       cls_c, cls_b;
  res_t [NUM_OPERANDS-1:0]       res_c, res_q;
  logic [ID_W-1:0]               id_b, id_q;

  assign vld_src = {vld_pipe, in_valid};

  // A stage may load when empty or when its successor is loading.
  always_comb begin
    en = '0;
    en[LATENCY+1] = out_ready;
    for (int k = LATENCY; k >= 1; k--) en[k] = ~vld_pipe[k] | en[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else
      for (int k = 1; k <= LATENCY; k++)
        if (en[k]) vld_pipe[k] <= vld_src[k-1];
  end

  for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_lane
    fp_rs_lane u_lane (
      .rs     (in_rs[i]),
      .single (in_single[i]),
      .ftz    (ftz),
      .cls    (cls_c[i]),
      .cls_q  (cls_b[i]),
      .res    (res_c[i])
    );
    assign out_double[i]        = res_q[i].dbl;
    assign out_special[i]       = res_q[i].special;
    assign out_is_boxed[i]      = res_q[i].boxed;
    assign out_hidden[i]        = res_q[i].hidden;
    assign out_prenorm_frac[i]  = res_q[i].frac;
    assign out_prenorm_shift[i] = res_q[i].shift;
  end

  if (LATENCY == 2) begin : g_l2
    cls_t [NUM_OPERANDS-1:0] s1_cls;
    logic [ID_W-1:0]         s1_id;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_cls <= '0;
        s1_id  <= '0;
      end else if (en[1]) begin
        s1_cls <= cls_c;
        s1_id  <= in_id;
      end
    end
    assign cls_b = s1_cls;
    assign id_b  = s1_id;
  end else begin : g_l1
    assign cls_b = cls_c;
    assign id_b  = in_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      id_q  <= '0;
    end else if (en[LATENCY]) begin
      res_q <= res_c;
      id_q  <= id_b;
    end
  end

  assign in_ready  = en[1];
  assign out_valid = vld_pipe[LATENCY];
  assign out_id    = id_q;
endmodule

// File: tb/tb_fp_rs_preprocess_pipe.sv
// Directed bench for fp_rs_preprocess_pipe (NUM_OPERANDS=3, LATENCY=2); FTZ case when FP_PRENORM_FTZ_EN is set.
module tb_fp_rs_preprocess_pipe;
  logic             clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic             in_valid = 1'b0, out_ready = 1'b1;
  logic             in_ready, out_valid;
  logic [2:0]       in_id = '0, out_id;
  logic [2:0][63:0] in_rs = '0;
  logic [2:0]       in_single = '0;
  logic [2:0][63:0] out_double;
  logic [2:0][3:0]  out_special;
  logic [2:0]       out_is_boxed, out_hidden;
  logic [2:0][51:0] out_prenorm_frac;
  logic [2:0][5:0]  out_prenorm_shift;
`ifdef FP_PRENORM_FTZ_EN
  logic             ftz = 1'b0;
`endif

  fp_rs_preprocess_pipe #(.NUM_OPERANDS(3), .LATENCY(2), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef FP_PRENORM_FTZ_EN
    .ftz(ftz),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_rs(in_rs), .in_single(in_single),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_double(out_double),
    .out_special(out_special), .out_is_boxed(out_is_boxed), .out_hidden(out_hidden),
    .out_prenorm_frac(out_prenorm_frac), .out_prenorm_shift(out_prenorm_shift)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int q_id[$], q_op[$];
  logic [63:0] t_rs[5][3], t_db[5][3];
  logic        t_sg[5][3], t_bx[5][3], t_hd[5][3];
  logic [3:0]  t_sp[5][3];
  logic [51:0] t_fr[5][3];
  logic [5:0]  t_sh[5][3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_vec(input int o, input int c, input logic [63:0] rs, input logic sg,
                         input logic [63:0] db, input logic [3:0] sp, input logic bx,
                         input logic hd, input logic [51:0] fr, input logic [5:0] sh);
    t_rs[o][c] = rs; t_sg[o][c] = sg; t_db[o][c] = db; t_sp[o][c] = sp;
    t_bx[o][c] = bx; t_hd[o][c] = hd; t_fr[o][c] = fr; t_sh[o][c] = sh;
  endtask

  task automatic drive(input int id, input int op);
    in_id = 3'(id);
    for (int c = 0; c < 3; c++) begin
      in_rs[c]     = t_rs[op][c];
      in_single[c] = t_sg[op][c];
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int id, input int op, input bit track);
    bit ok = 1'b0;
    drive(id, op);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk($sformatf("send_id%0d_ready", id), {63'b0, in_ready}, 64'd1);
    else if (track) begin q_id.push_back(id); q_op.push_back(op); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (q_id.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_left", 64'(q_id.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    int mid, mop;
    if (rst_n && out_valid && out_ready) begin
      if (q_id.size() == 0) chk("extra_out_valid", {63'b0, out_valid}, 64'd0);
      else begin
        mid = q_id.pop_front();
        mop = q_op.pop_front();
        chk("out_id", {61'b0, out_id}, 64'(mid[2:0]));
        for (int c = 0; c < 3; c++) begin
          if (t_sg[mop][c]) chk($sformatf("id%0d_c%0d_dbl", mid, c), out_double[c], t_db[mop][c]);
          chk($sformatf("id%0d_c%0d_special", mid, c), 64'(out_special[c]), 64'(t_sp[mop][c]));
          chk($sformatf("id%0d_c%0d_boxed", mid, c), 64'(out_is_boxed[c]), 64'(t_bx[mop][c]));
          chk($sformatf("id%0d_c%0d_hidden", mid, c), 64'(out_hidden[c]), 64'(t_hd[mop][c]));
          chk($sformatf("id%0d_c%0d_frac", mid, c), 64'(out_prenorm_frac[c]), 64'(t_fr[mop][c]));
          chk($sformatf("id%0d_c%0d_shift", mid, c), 64'(out_prenorm_shift[c]), 64'(t_sh[mop][c]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  snap_id;
    logic [63:0] snap_db;
    //          op ch rs                      sg dbl                     spec    bx hd frac              sh
    set_vec(0, 0, 64'hFFFFFFFF_3F800000, 1, 64'h3FF0000000000000, 4'b0000, 1, 1, 52'h0,             6'd0);
    set_vec(0, 1, 64'h00000000_3F800000, 1, 64'h7FF8000000000000, 4'b0010, 0, 1, 52'h0,             6'd0);
    set_vec(0, 2, 64'h0000000000000001, 0, 64'h0,                 4'b0000, 0, 0, 52'h0,             6'd52);
    set_vec(1, 0, 64'hFFFFFFFF_00000001, 1, 64'h36A0000000000000, 4'b0000, 1, 0, 52'h0,             6'd0);
    set_vec(1, 1, 64'h3FF0000000000000, 0, 64'h0,                 4'b0000, 0, 1, 52'h0,             6'd0);
    set_vec(1, 2, 64'hFFFFFFFF_7F800001, 1, 64'h7FF8000000000000, 4'b0100, 1, 1, 52'h20000000,      6'd0);
    set_vec(2, 0, 64'hFFFFFFFF_FF800000, 1, 64'hFFF0000000000000, 4'b1000, 1, 1, 52'h0,             6'd0);
    set_vec(2, 1, 64'hFFFFFFFF_80000000, 1, 64'h8000000000000000, 4'b0001, 1, 0, 52'h0,             6'd0);
    set_vec(2, 2, 64'h0004000000000003, 0, 64'h0,                 4'b0000, 0, 0, 52'hC,             6'd2);
    set_vec(3, 0, 64'hFFFFFFFF_40490FDB, 1, 64'h400921FB60000000, 4'b0000, 1, 1, 52'h921FB60000000, 6'd0);
    set_vec(3, 1, 64'hFFFFFFFF_00400000, 1, 64'h3800000000000000, 4'b0000, 1, 0, 52'h0,             6'd0);
    set_vec(3, 2, 64'h7FF8000000000000, 0, 64'h0,                 4'b0010, 0, 1, 52'h8000000000000, 6'd0);
    set_vec(4, 0, 64'hFFFFFFFF_80000001, 1, 64'h8000000000000000, 4'b0001, 1, 0, 52'h0,             6'd0);
    set_vec(4, 1, 64'h8000000000000001, 0, 64'h0,                 4'b0001, 0, 0, 52'h0,             6'd0);
    set_vec(4, 2, 64'hFFFFFFFF_3F800000, 1, 64'h3FF0000000000000, 4'b0000, 1, 1, 52'h0,             6'd0);

    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_id", {61'b0, out_id}, 64'd0);
    chk("rst_out_double0", out_double[0], 64'd0);
    chk("rst_frac2", 64'(out_prenorm_frac[2]), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: exactly two edges from accept to out_valid.
    drive(1, 0);
    q_id.push_back(1); q_op.push_back(0);
    chk("lat_in_ready", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("lat_after1", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_after2", {63'b0, out_valid}, 64'd1);
    chk("lat_id", {61'b0, out_id}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back stream with a 3-cycle stall.
    fork
      for (int i = 0; i < 6; i++) send(i, i % 4, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        snap_id = out_id;
        snap_db = out_double[0];
        chk("stall_valid", {63'b0, out_valid}, 64'd1);
        chk("stall_id", {61'b0, out_id}, 64'd1);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        repeat (2) begin
          @(negedge clk);
          chk("stall_id_hold", {61'b0, out_id}, {61'b0, snap_id});
          chk("stall_dbl_hold", out_double[0], snap_db);
          chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("resume_in_ready", {63'b0, in_ready}, 64'd1);
      end
    join
    drain();

    // Bubble collapse: empty first stage accepts while the output stalls.
    out_ready = 1'b0;
    send(6, 1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_valid", {63'b0, out_valid}, 64'd1);
    chk("bubble_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(7, 2, 1'b1);
    @(negedge clk);
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

`ifdef FP_PRENORM_FTZ_EN
    ftz = 1'b1;
    send(4, 4, 1'b1);
    ftz = 1'b0;
    drain();
`endif

    // Flush with two in flight and a simultaneous input.
    out_ready = 1'b0;
    send(0, 0, 1'b0);
    send(1, 1, 1'b0);
    chk("flush_pre_valid", {63'b0, out_valid}, 64'd1);
    flush = 1'b1;
    drive(2, 2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_empty", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(3, 3, 1'b0);
    @(posedge clk); #1;
    chk("arst_pre_valid", {63'b0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("arst_id", {61'b0, out_id}, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_empty", {63'b0, out_valid}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_rs_preprocess_pipe.md
Name: fp_rs_preprocess_pipe

Overview:
- Pipelined, multi-operand successor to the FP register-source preprocessor.
- Per operand, in parallel: NaN-box check, special-case classification, CLZ prenormalization and single-to-double widening, for NUM_OPERANDS sources (FMA needs 3).
- Registered over LATENCY stages with an elastic valid/ready pipeline and an ID passthrough.
- Sits between FP issue and the FP execution units.

Parameters:
- NUM_OPERANDS, 3, number of parallel operand channels (1..3).
- LATENCY, 2, pipeline stages (1 or 2).
  - 1: classify+CLZ+shift in one stage.
  - 2: classify+CLZ in stage 1; shift+exponent in stage 2.
- ID_W, 3, width of passthrough instruction ID.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops all in-flight entries.
- in_valid  in  1  input operands valid.
- in_ready  out  1  pipeline can accept.
- in_id  in  ID_W  instruction ID.
- in_rs  in  NUM_OPERANDS x 64  packed operands.
- in_single  in  NUM_OPERANDS  per-operand: 1 = single precision (NaN-boxed), 0 = double.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts.
- out_id  out  ID_W  ID of the result.
- out_double  out  NUM_OPERANDS x 64  widened double (meaningful only for single channels).
- out_special  out  NUM_OPERANDS x 4  {inf, snan, qnan, zero}.
- out_is_boxed  out  NUM_OPERANDS  upper 32 bits all ones.
- out_hidden  out  NUM_OPERANDS  implicit leading bit (single: ~zero_s; double: nonzero exponent).
- out_prenorm_frac  out  NUM_OPERANDS x 52  normalized fraction.
- out_prenorm_shift  out  NUM_OPERANDS x 6  CLZ shift. Double channels only; 0 for single.

Behaviour:
- Reset: all stage valids 0 → out_valid=0, in_ready=1. All data registers 0.
- rst_n is asynchronous; assertion mid-operation discards every entry.
- Stage enable: en[k] = ~valid[k] | en[k+1]; last stage: en = ~out_valid | out_ready.
  - in_ready = en[0]. Transfer occurs when in_valid & in_ready.
  - Data registers load only on en.
  - Full throughput: one op/cycle when out_ready is held high.
  - Latency: LATENCY cycles from accept to out_valid.
- Backpressure: out_ready=0 holds every output stable. Bubbles collapse: an empty stage accepts even while downstream stalls.
- flush: all valids ← 0 next cycle. A simultaneous in_valid is dropped. flush has priority over accept.
- Classification, single channel:
  - inf, snan and zero are ANDed with is_boxed.
  - qnan is ORed with ~is_boxed.
- Prenormalization:
  - CLZ over {hidden, frac52, 1'b1} (54 bits).
  - Single fraction is left-aligned into frac52.
  - prenorm_frac = frac52 << clz, truncated to 52 bits.
- Single→double widening:
  - expo = 896 + expo_s when normal.
  - expo = 897 − clz when subnormal.
  - inf / NaN / unboxed → expo 0x7FF.
  - zero → expo 0.
  - NaN or unboxed → canonical 0x7FF8000000000000, sign 0.
  - Otherwise sign passes through.
- With LATENCY=2, the stage-1 register holds per channel: raw operand, single, classification and clz count. Stage 2 computes the shift and exponent.
- Channels are fully independent; mixed single/double in one op is legal.

Optional Feature:
- Macro: FP_PRENORM_FTZ_EN.
- Defined: adds input port ftz (1 bit, sampled with the operands at accept). When ftz=1:
  - A subnormal input (either precision, boxed) is treated as signed zero.
  - zero flag = 1, hidden = 0, prenorm_frac = 0, prenorm_shift = 0.
  - out_double = sign‖63'b0.
- Undefined: no ftz port; subnormals are always prenormalized as above.

Test Plan:
- Single 1.0, boxed: in_rs=0xFFFFFFFF_3F800000, single=1 → out_double=0x3FF0000000000000, special=0000, hidden=1, appears exactly LATENCY cycles after accept.
- Unboxed single: 0x00000000_3F800000 → qnan=1, is_boxed=0, out_double=0x7FF8000000000000.
- Single subnormal: 0xFFFFFFFF_00000001 → out_double=0x36A0000000000000, hidden=0. Double subnormal 0x0000000000000001 → prenorm_shift=52, prenorm_frac=0.
- Backpressure: stream IDs 0..5 back-to-back with out_ready low for 3 cycles mid-stream.
  - Outputs held stable during the stall; in_ready falls only when all stages are full.
  - IDs emerge in order with none lost or duplicated.
- Flush and reset: flush with 2 entries in flight plus a simultaneous in_valid → out_valid=0 next cycle and nothing emerges. rst_n pulsed low mid-stream → out_valid=0 immediately, no clock needed.
- FTZ, with FP_PRENORM_FTZ_EN and ftz=1: single 0xFFFFFFFF_80000001 → zero=1, out_double=0x8000000000000000.
